// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared constants for the on-chip memory arbiter.
// Holds the FSM state encodings, the response codes and the default
// ADDR_W / DATA_W / DEPTH values used as parameter defaults by the top.
package onchip_arb_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 12000;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with last-grant register.
// Ports: clk, reset_n (async, active-low); req[1:0] request vector;
// load captures the current grant as the new last grant;
// gnt is the combinational winner index; last is the registered last grant,
// which resets to master 1 so master 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       load,
    output logic       gnt,
    output logic       last
);
    assign gnt = &req ? ~last : req[1];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last <= 1'b1;
        else if (load) last <= gnt;
    end
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-master round-robin arbiter in front of a single-port RAM.
// Ports: clk, reset_n (async, active-low);
//   mN_address/byteenable/read/write/writedata  master N request (N = 0,1);
//   mN_waitrequest/readdata/readdatavalid/response  master N return path;
//   mem_address/byteenable/writedata/chipselect/write/clken  RAM controls;
//   mem_readdata  RAM output, valid one cycle after the address is clocked.
// Macro ONCHIP_ARB_RANGE_CHECK_EN: addresses >= DEPTH are accepted but not
// forwarded to the RAM and complete with SLVERR (reads return zero).
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic [1:0]        m0_response,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [1:0]        m1_response,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
`ifdef ONCHIP_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    logic [1:0]        state;
    logic [1:0]        req;
    logic [1:0]        resp0_q, resp1_q;
    logic [1:0]        wresp, rresp;
    logic [DATA_W-1:0] rdata;
    logic              sel, arb_gnt, issue, sel_wr, err, err_q;
    assign req = {m1_read | m1_write, m0_read | m0_write};
    // The last-grant register doubles as the grant of the transaction in flight.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .load    (state == ST_IDLE && |req),
        .gnt     (arb_gnt),
        .last    (sel)
    );
    assign issue          = state == ST_ISSUE;
    // write wins over read when a master raises both strobes
    assign sel_wr         = sel ? m1_write : m0_write;
    assign mem_address    = sel ? m1_address : m0_address;
    assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = sel ? m1_writedata : m0_writedata;
    assign err            = RANGE_EN && (32'(mem_address) >= DEPTH);
    assign mem_chipselect = issue && !err;
    assign mem_write      = mem_chipselect && sel_wr;
    assign mem_clken      = 1'b1;
    assign m0_waitrequest = !(issue && !sel);
    assign m1_waitrequest = !(issue && sel);
    assign wresp          = err ? RESP_SLVERR : RESP_OKAY;
    assign rresp          = err_q ? RESP_SLVERR : RESP_OKAY;
    assign rdata          = err_q ? '0 : mem_readdata;
    // Write responses are combinational in the accept cycle; read responses ride with readdatavalid.
    assign m0_response    = (issue && !sel && sel_wr) ? wresp : resp0_q;
    assign m1_response    = (issue && sel && sel_wr) ? wresp : resp1_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            err_q            <= 1'b0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            resp0_q          <= RESP_OKAY;
            resp1_q          <= RESP_OKAY;
        end else begin
            state <= state == ST_IDLE  ? (|req ? ST_ISSUE : ST_IDLE) :
                     state == ST_ISSUE ? (sel_wr ? ST_IDLE : ST_RDATA) : ST_IDLE;
            if (issue) err_q <= err;
            m0_readdatavalid <= state == ST_RDATA && !sel;
            m1_readdatavalid <= state == ST_RDATA && sel;
            if (state == ST_RDATA && !sel) begin
                m0_readdata <= rdata;
                resp0_q     <= rresp;
            end
            if (state == ST_RDATA && sel) begin
                m1_readdata <= rdata;
                resp1_q     <= rresp;
            end
        end
    end
endmodule
